mem_stage_ctrl: RTL and testbench

- MEM-stage controller at the consumer end of the EX/MEM pipeline buffer; takes the buffered control, address, data and jump fields.
- Drives a req/ack data-memory bus and holds the pipeline stalled while an access is in flight.
- Resolves branch and jump redirects.
- Registers results into MEM/WB outputs for the write-back stage.

---
 rtl/mem_stage_ctrl_if.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and memory.
// The controller owns the request side; memory returns read data with a one-cycle ack pulse.
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory access FSM with bus timeout, branch/jump resolve, MEM/WB register.
// Optional macro MISALIGN_CHECK_EN rejects non-word-aligned accesses instead of truncating the address.
module mem_stage_ctrl #(
    parameter int TIMEOUT    = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            in_M,
    input  logic [1:0]            in_WB,
    input  logic [31:0]           in_add,
    input  logic                  in_flag,
    input  logic [31:0]           in_res,
    input  logic [31:0]           in_dat2,
    input  logic [4:0]            in_mux,
    input  logic [27:0]           in_ShfJ,
    input  logic                  J_in,
    input  logic [3:0]            pc_hi,
    output logic                  pc_src,
    output logic                  jmp,
    output logic [31:0]           br_target,
    output logic [31:0]           j_target,
    output logic                  stall,
    mem_stage_ctrl_if.master      bus,
    output logic [1:0]            ou_WB,
    output logic [31:0]           ou_rdata,
    output logic [31:0]           ou_res,
    output logic [4:0]            ou_mux,
    output logic                  ou_valid,
    output logic                  err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = DEPTH_LOG2'(TIMEOUT - 1);

    state_t                r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_cnt, w_cnt_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic                  r_mem_we, w_mem_we_nxt;
    logic [31:0]           r_mem_addr, w_mem_addr_nxt;
    logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
    logic [1:0]            r_ou_WB, w_ou_WB_nxt;
    logic [31:0]           r_ou_rdata, w_ou_rdata_nxt;
    logic [31:0]           r_ou_res, w_ou_res_nxt;
    logic [4:0]            r_ou_mux, w_ou_mux_nxt;
    logic                  r_ou_valid, w_ou_valid_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_acc, w_misalign, w_stall;

    assign w_acc = in_valid & (in_M[1] | in_M[0]);

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = (in_res[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ou_WB     <= '0;
            r_ou_rdata  <= '0;
            r_ou_res    <= '0;
            r_ou_mux    <= '0;
            r_ou_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ou_WB     <= w_ou_WB_nxt;
            r_ou_rdata  <= w_ou_rdata_nxt;
            r_ou_res    <= w_ou_res_nxt;
            r_ou_mux    <= w_ou_mux_nxt;
            r_ou_valid  <= w_ou_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ou_WB_nxt     = r_ou_WB;
        w_ou_rdata_nxt  = r_ou_rdata;
        w_ou_res_nxt    = r_ou_res;
        w_ou_mux_nxt    = r_ou_mux;
        w_ou_valid_nxt  = r_ou_valid;
        w_err_nxt       = r_err;
        w_stall         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && !w_misalign) begin
                    w_stall         = 1'b1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = in_M[0];
                    w_mem_addr_nxt  = {in_res[31:2], 2'b00};
                    w_mem_wdata_nxt = in_dat2;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_BUSY;
                end else if (w_acc) begin
                    w_ou_WB_nxt    = {1'b0, in_WB[0]};
                    w_ou_rdata_nxt = '0;
                    w_ou_res_nxt   = in_res;
                    w_ou_mux_nxt   = in_mux;
                    w_ou_valid_nxt = 1'b1;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_ou_WB_nxt    = in_WB;
                    w_ou_rdata_nxt = '0;
                    w_ou_res_nxt   = in_res;
                    w_ou_mux_nxt   = in_mux;
                    w_ou_valid_nxt = in_valid;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack) begin
                    w_ou_WB_nxt    = in_WB;
                    w_ou_rdata_nxt = r_mem_we ? 32'h0 : bus.mem_rdata;
                    w_ou_res_nxt   = in_res;
                    w_ou_mux_nxt   = in_mux;
                    w_ou_valid_nxt = 1'b1;
                    w_mem_req_nxt  = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    // Abort commits the slot with its register write suppressed so upstream can advance.
                    w_ou_WB_nxt    = {1'b0, in_WB[0]};
                    w_ou_rdata_nxt = '0;
                    w_ou_res_nxt   = in_res;
                    w_ou_mux_nxt   = in_mux;
                    w_ou_valid_nxt = 1'b1;
                    w_mem_req_nxt  = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign stall         = w_stall;
    assign pc_src        = in_valid & in_M[2] & in_flag;
    assign jmp           = in_valid & J_in;
    assign br_target     = in_add;
    assign j_target      = {pc_hi, in_ShfJ};
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign ou_WB         = r_ou_WB;
    assign ou_rdata      = r_ou_rdata;
    assign ou_res        = r_ou_res;
    assign ou_mux        = r_ou_mux;
    assign ou_valid      = r_ou_valid;
    assign err           = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reset, branch/jump, load, store, idle ack, timeout, reset mid-access.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_M;
    logic [1:0]  in_WB;
    logic [31:0] in_add;
    logic        in_flag;
    logic [31:0] in_res;
    logic [31:0] in_dat2;
    logic [4:0]  in_mux;
    logic [27:0] in_ShfJ;
    logic        J_in;
    logic [3:0]  pc_hi;
    logic        pc_src, jmp, stall, ou_valid, err;
    logic [31:0] br_target, j_target, ou_rdata, ou_res;
    logic [1:0]  ou_WB;
    logic [4:0]  ou_mux;

    int n_assert = 0;
    int n_fail   = 0;
    int n_stall;
    int n_req;

    mem_stage_ctrl_if bus();

    mem_stage_ctrl #(.TIMEOUT(16), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_M(in_M), .in_WB(in_WB), .in_add(in_add),
        .in_flag(in_flag), .in_res(in_res), .in_dat2(in_dat2), .in_mux(in_mux),
        .in_ShfJ(in_ShfJ), .J_in(J_in), .pc_hi(pc_hi),
        .pc_src(pc_src), .jmp(jmp), .br_target(br_target), .j_target(j_target),
        .stall(stall), .bus(bus),
        .ou_WB(ou_WB), .ou_rdata(ou_rdata), .ou_res(ou_res), .ou_mux(ou_mux),
        .ou_valid(ou_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        in_valid = 1'b0; in_M = 3'b000; in_WB = 2'b00; in_add = '0; in_flag = 1'b0;
        in_res = '0; in_dat2 = '0; in_mux = '0; in_ShfJ = '0; J_in = 1'b0; pc_hi = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bubble();
        tick(); tick();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_ou_valid", 32'(ou_valid), 32'd0);
        chk("rst_ou_rdata", ou_rdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Branch taken, no memory activity
        in_valid = 1'b1; in_M = 3'b100; in_flag = 1'b1; in_add = 32'h40;
        in_res = 32'h55; in_mux = 5'd3; in_WB = 2'b00;
        #1;
        chk("br_pc_src", 32'(pc_src), 32'd1);
        chk("br_target", br_target, 32'h40);
        chk("br_stall", 32'(stall), 32'd0);
        chk("br_jmp", 32'(jmp), 32'd0);
        tick();
        chk("br_mem_req", 32'(bus.mem_req), 32'd0);
        chk("br_ou_valid", 32'(ou_valid), 32'd1);
        chk("br_ou_res", ou_res, 32'h55);
        chk("br_ou_mux", 32'(ou_mux), 32'd3);
        in_flag = 1'b0;
        #1;
        chk("br_not_taken", 32'(pc_src), 32'd0);

        // Jump, then jump+branch together, then bubble masking
        in_M = 3'b000; J_in = 1'b1; pc_hi = 4'hA; in_ShfJ = 28'h0000100;
        #1;
        chk("j_jmp", 32'(jmp), 32'd1);
        chk("j_target", j_target, 32'hA000_0100);
        in_M = 3'b100; in_flag = 1'b1;
        #1;
        chk("bj_pc_src", 32'(pc_src), 32'd1);
        chk("bj_jmp", 32'(jmp), 32'd1);
        in_valid = 1'b0;
        #1;
        chk("bub_pc_src", 32'(pc_src), 32'd0);
        chk("bub_jmp", 32'(jmp), 32'd0);
        bubble();
        tick();

        // Load: three wait cycles then ack
        in_valid = 1'b1; in_M = 3'b010; in_res = 32'h0000_0104; in_WB = 2'b11; in_mux = 5'd7;
        #1;
        n_stall = 0;
        n_stall += int'(stall);
        tick();
        chk("ld_mem_req", 32'(bus.mem_req), 32'd1);
        chk("ld_mem_addr", bus.mem_addr, 32'h104);
        chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
        n_stall += int'(stall);
        tick(); n_stall += int'(stall);
        tick(); n_stall += int'(stall);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_stall += int'(stall);
        chk("ld_stall_cycles", 32'(n_stall), 32'd4);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("ld_req_drop", 32'(bus.mem_req), 32'd0);
        chk("ld_ou_rdata", ou_rdata, 32'hDEAD_BEEF);
        chk("ld_ou_valid", 32'(ou_valid), 32'd1);
        chk("ld_ou_WB", 32'(ou_WB), 32'd3);
        chk("ld_ou_res", ou_res, 32'h104);

        // Store: one wait cycle then ack; read data must be ignored
        in_M = 3'b001; in_res = 32'h0000_0200; in_dat2 = 32'h1234_5678; in_WB = 2'b00; in_mux = 5'd0;
        #1;
        n_stall = 0;
        n_stall += int'(stall);
        tick();
        chk("st_mem_we", 32'(bus.mem_we), 32'd1);
        chk("st_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("st_mem_addr", bus.mem_addr, 32'h200);
        n_stall += int'(stall);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("st_we_held", 32'(bus.mem_we), 32'd1);
        n_stall += int'(stall);
        chk("st_stall_cycles", 32'(n_stall), 32'd2);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("st_ou_rdata", ou_rdata, 32'h0);
        chk("st_ou_valid", 32'(ou_valid), 32'd1);
        chk("st_req_drop", 32'(bus.mem_req), 32'd0);

        // Stray ack while idle with a bubble in the slot
        bubble();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("idle_ack_req", 32'(bus.mem_req), 32'd0);
        chk("idle_ack_valid", 32'(ou_valid), 32'd0);
        chk("idle_ack_rdata", ou_rdata, 32'h0);

        // Timeout: load never acknowledged
        in_valid = 1'b1; in_M = 3'b010; in_res = 32'h0000_0300; in_WB = 2'b11; in_mux = 5'd9;
        tick();
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_req) break;
            n_req++;
            if (n_req == 16) chk("to_stall_release", 32'(stall), 32'd0);
            tick();
        end
        chk("to_req_cycles", 32'(n_req), 32'd16);
        chk("to_err", 32'(err), 32'd1);
        chk("to_ou_WB", 32'(ou_WB), 32'd1);
        chk("to_ou_valid", 32'(ou_valid), 32'd1);
        chk("to_ou_rdata", ou_rdata, 32'h0);
        chk("to_ou_res", ou_res, 32'h300);
        bubble();
        #1;
        chk("to_stall_idle", 32'(stall), 32'd0);
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of an access
        in_valid = 1'b1; in_M = 3'b010; in_res = 32'h0000_0400; in_WB = 2'b11; in_mux = 5'd4;
        tick();
        chk("rb_req_busy", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rb_req_async", 32'(bus.mem_req), 32'd0);
        chk("rb_err_clr", 32'(err), 32'd0);
        tick();
        chk("rb_no_valid", 32'(ou_valid), 32'd0);
        rst = 1'b0;

        // First access after reset completes normally; low address bits dropped
        in_res = 32'h0000_010A; in_mux = 5'd12;
        #1;
        chk("rc_stall", 32'(stall), 32'd1);
        tick();
        chk("rc_mem_addr", bus.mem_addr, 32'h108);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("rc_stall_ack", 32'(stall), 32'd0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("rc_ou_rdata", ou_rdata, 32'h0BAD_F00D);
        chk("rc_ou_valid", 32'(ou_valid), 32'd1);
        chk("rc_ou_res", ou_res, 32'h10A);
        chk("rc_ou_mux", 32'(ou_mux), 32'd12);
        chk("rc_err", 32'(err), 32'd0);
        bubble();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
